tlb_ctrl: RTL and testbench
===========================

TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 16, number of TLB entries (power of two; index width IW = log2(TLB_ENTRIES)).
REQ-002 SHALL have parameter ENTRY_W, default 68, packed entry width {vpn2[18:0], asid[7:0], G, pfn0[19:0], pfn1[19:0]}.
REQ-003 SHALL have ports:
 clk  in  1  sole clock;
 resetn  in  1  asynchronous active-low reset;
 i_req / i_vaddr / i_ready  in 1 / in 32 / out 1  fetch lookup request;
 i_valid / i_paddr / i_miss  out 1 / out 32 / out 1  fetch response;
 d_req / d_vaddr / d_ready  in 1 / in 32 / out 1  data lookup request;
 d_valid / d_paddr / d_miss  out 1 / out 32 / out 1  data response;
 op_valid / op / op_ready / op_done  in 1 / in 2 / out 1 / out 1  TLB instruction (00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR);
 entryhi / entrylo0 / entrylo1  in 32 each  CP0 source values (vpn2=[31:13], asid=[7:0], pfn=lo[25:6], G=lo0[0]&lo1[0]);
 index / wired  in IW each  CP0 Index and Wired;
 p_index  out 32  TLBP result, bit31 = probe miss;
 r_entryhi / r_entrylo0 / r_entrylo1  out 32 each  TLBR results;
 lut_vaddr / lut_asid  out 32 / out 8  shared lookup port drive;
 lut_hit / lut_index / lut_paddr  in 1 / in IW / in 32  shared lookup result (combinational);
 tlb_raddr / tlb_rentry  out IW / in ENTRY_W  table read port (combinational);
 tlb_we / tlb_waddr / tlb_wentry  out 1 / out IW / out ENTRY_W  table write port.

Function
REQ-004 SHALL run FSM states IDLE, PROBE, READ, WRITE; PROBE/READ/WRITE each last exactly one cycle, then return to IDLE.
REQ-005 In IDLE, op_ready=1; op_valid&op_ready at cycle t SHALL move to PROBE (TLBP), READ (TLBR) or WRITE (TLBWI/TLBWR) at t+1.
REQ-006 Priority per IDLE cycle SHALL be op > d_req > i_req (strict); i_ready=~op_valid&~d_req, d_ready=~op_valid; both ready=0 outside IDLE.
REQ-007 Granted lookup SHALL drive lut_vaddr=granted vaddr, lut_asid=entryhi[7:0]; x_valid pulses at t+1 with registered x_paddr=lut_paddr, x_miss=~lut_hit.
REQ-008 In PROBE SHALL drive lut_vaddr={entryhi[31:13],13'b0}; at the same cycle op_done=1 and p_index registered to {~lut_hit, 0, lut_index} (visible t+2, held until next TLBP).
REQ-009 In READ SHALL drive tlb_raddr=index; r_entryhi={vpn2,5'b0,asid}, r_entrylo0/1={6'b0,pfn,5'b0,G} registered, visible t+2, op_done=1 in READ cycle.
REQ-010 In WRITE SHALL assert tlb_we for exactly one cycle, tlb_waddr=index (TLBWI) or random (TLBWR), tlb_wentry packed from entryhi/entrylo0/1; op_done=1 same cycle.
REQ-011 A lookup granted after WRITE (earliest t+2) SHALL observe the new entry.
REQ-012 Random counter SHALL decrement by 1 every cycle; at value <= wired it SHALL wrap to TLB_ENTRIES-1; if wired >= TLB_ENTRIES-1 it holds TLB_ENTRIES-1.
REQ-013 Simultaneous i_req and d_req SHALL grant d only; i_req must be held until i_ready (no starvation guard).
REQ-014 Requests presented while not ready SHALL be neither lost nor answered; x_valid never asserts without a prior accepted request.
REQ-015 op_done SHALL pulse exactly once per accepted op; back-to-back ops accepted every 2 cycles.

Reset
REQ-016 resetn low SHALL immediately force state=IDLE, random=TLB_ENTRIES-1, all valid/done/we outputs 0, p_index/r_* registers 0, independent of clk.
REQ-017 Reset mid-WRITE SHALL suppress tlb_we that cycle; no partial write.

Configuration
REQ-018 Macro TLB_KSEG_BYPASS_EN defined: vaddr[31:30]==2'b10 (kseg0/kseg1) SHALL bypass lookup, x_paddr={3'b0,vaddr[28:0]}, x_miss=0, same 1-cycle latency.
REQ-019 Macro undefined: all addresses SHALL go through lut; no bypass logic present.

Verification
REQ-020 Reset then idle 20 cycles, wired=4 -> random sequence 15,14,...,4,15 repeating; no valid pulses.
REQ-021 i_req and d_req same cycle, d_vaddr=0x0040_2000 -> d granted, d_valid next cycle, i_ready=0; i served the following cycle.
REQ-022 TLBWI index=3, entryhi=0x0040_2005, lo0 pfn=0x12345 -> tlb_we one cycle, waddr=3; then d_vaddr=0x0040_2ABC asid 5 -> d_paddr=0x12345ABC, d_miss=0.
REQ-023 TLBP with entryhi vpn2 absent -> p_index=0x8000_0000; after REQ-022 write -> p_index=3.
REQ-024 With TLB_KSEG_BYPASS_EN, i_vaddr=0xBFC0_0000 -> i_paddr=0x1FC0_0000, i_miss=0, lut result ignored.
REQ-025 resetn low during WRITE cycle -> tlb_we=0, op_done=0, FSM IDLE on release.

Source files
------------

// File: rtl/tlb_ctrl.sv
// TLB controller: arbitrates fetch/data lookups and TLBP/TLBR/TLBWI/TLBWR over an external entry table.
// Define TLB_KSEG_BYPASS_EN to translate kseg0/kseg1 addresses directly without a table lookup.

module tlb_ctrl #(
    parameter int TLB_ENTRIES = 16,
    parameter int ENTRY_W     = 68,
    localparam int IW         = $clog2(TLB_ENTRIES)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_req,
    input  logic [31:0]        i_vaddr,
    output logic               i_ready,
    output logic               i_valid,
    output logic [31:0]        i_paddr,
    output logic               i_miss,
    input  logic               d_req,
    input  logic [31:0]        d_vaddr,
    output logic               d_ready,
    output logic               d_valid,
    output logic [31:0]        d_paddr,
    output logic               d_miss,
    input  logic               op_valid,
    input  logic [1:0]         op,
    output logic               op_ready,
    output logic               op_done,
    input  logic [31:0]        entryhi,
    input  logic [31:0]        entrylo0,
    input  logic [31:0]        entrylo1,
    input  logic [IW-1:0]      index,
    input  logic [IW-1:0]      wired,
    output logic [31:0]        p_index,
    output logic [31:0]        r_entryhi,
    output logic [31:0]        r_entrylo0,
    output logic [31:0]        r_entrylo1,
    output logic [31:0]        lut_vaddr,
    output logic [7:0]         lut_asid,
    input  logic               lut_hit,
    input  logic [IW-1:0]      lut_index,
    input  logic [31:0]        lut_paddr,
    output logic [IW-1:0]      tlb_raddr,
    input  logic [ENTRY_W-1:0] tlb_rentry,
    output logic               tlb_we,
    output logic [IW-1:0]      tlb_waddr,
    output logic [ENTRY_W-1:0] tlb_wentry
);

    localparam logic [IW-1:0] RAND_TOP = IW'(TLB_ENTRIES - 1);
    localparam int VPN2_LSB = 49;
    localparam int ASID_LSB = 41;
    localparam int G_BIT    = 40;
    localparam int PFN0_LSB = 20;
    localparam int PFN1_LSB = 0;

    typedef enum logic [1:0] {IDLE, PROBE, READ, WRITE} state_t;

    state_t        state;
    state_t        state_next;
    logic          op_is_wr;
    logic [IW-1:0] random;
    logic          grant_i;
    logic          grant_d;
    logic [31:0]   lk_paddr;
    logic          lk_miss;
    logic [ENTRY_W-1:0] new_entry;
    logic [18:0]   rd_vpn2;
    logic [7:0]    rd_asid;
    logic          rd_g;
    logic [19:0]   rd_pfn0;
    logic [19:0]   rd_pfn1;
    logic          unused_cp0;

    assign new_entry = {entryhi[31:13], entryhi[7:0], entrylo0[0] & entrylo1[0],
                        entrylo0[25:6], entrylo1[25:6]};

    assign rd_vpn2 = tlb_rentry[VPN2_LSB +: 19];
    assign rd_asid = tlb_rentry[ASID_LSB +: 8];
    assign rd_g    = tlb_rentry[G_BIT];
    assign rd_pfn0 = tlb_rentry[PFN0_LSB +: 20];
    assign rd_pfn1 = tlb_rentry[PFN1_LSB +: 20];

    assign unused_cp0 = ^{entryhi[12:8], entrylo0[31:26], entrylo0[5:1],
                          entrylo1[31:26], entrylo1[5:1]};

    // Ops beat data lookups, data beats fetch; only IDLE accepts anything.
    always_comb begin
        state_next = state;
        op_ready   = 1'b0;
        op_done    = 1'b0;
        i_ready    = 1'b0;
        d_ready    = 1'b0;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        lut_vaddr  = i_vaddr;
        lut_asid   = entryhi[7:0];
        tlb_raddr  = index;
        tlb_we     = 1'b0;
        tlb_waddr  = index;
        tlb_wentry = new_entry;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                d_ready  = ~op_valid;
                i_ready  = ~op_valid & ~d_req;
                if (op_valid) begin
                    case (op)
                        2'b00:   state_next = PROBE;
                        2'b01:   state_next = READ;
                        default: state_next = WRITE;
                    endcase
                end else if (d_req) begin
                    grant_d   = 1'b1;
                    lut_vaddr = d_vaddr;
                end else if (i_req) begin
                    grant_i   = 1'b1;
                end
            end
            PROBE: begin
                lut_vaddr  = {entryhi[31:13], 13'b0};
                op_done    = 1'b1;
                state_next = IDLE;
            end
            READ: begin
                op_done    = 1'b1;
                state_next = IDLE;
            end
            WRITE: begin
                tlb_we     = 1'b1;
                tlb_waddr  = op_is_wr ? random : index;
                op_done    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        lk_paddr = lut_paddr;
        lk_miss  = ~lut_hit;
`ifdef TLB_KSEG_BYPASS_EN
        if (lut_vaddr[31:30] == 2'b10) begin
            lk_paddr = {3'b000, lut_vaddr[28:0]};
            lk_miss  = 1'b0;
        end
`endif
    end

    // Async reset drops the state out of WRITE at once, so tlb_we cannot complete.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            op_is_wr <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && op_valid) begin
                op_is_wr <= (op == 2'b11);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            random <= RAND_TOP;
        end else if (random <= wired) begin
            random <= RAND_TOP;
        end else begin
            random <= random - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_valid <= 1'b0;
            i_paddr <= '0;
            i_miss  <= 1'b0;
            d_valid <= 1'b0;
            d_paddr <= '0;
            d_miss  <= 1'b0;
        end else begin
            i_valid <= grant_i;
            d_valid <= grant_d;
            if (grant_i) begin
                i_paddr <= lk_paddr;
                i_miss  <= lk_miss;
            end
            if (grant_d) begin
                d_paddr <= lk_paddr;
                d_miss  <= lk_miss;
            end
        end
    end

    // Probe/read results stay put until the next op of the same kind.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_index    <= '0;
            r_entryhi  <= '0;
            r_entrylo0 <= '0;
            r_entrylo1 <= '0;
        end else begin
            if (state == PROBE) begin
                p_index <= {~lut_hit, {(31 - IW){1'b0}}, lut_index};
            end
            if (state == READ) begin
                r_entryhi  <= {rd_vpn2, 5'b0, rd_asid};
                r_entrylo0 <= {6'b0, rd_pfn0, 5'b0, rd_g};
                r_entrylo1 <= {6'b0, rd_pfn1, 5'b0, rd_g};
            end
        end
    end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Scoreboard bench for tlb_ctrl: behavioural table/CAM, queued expectations, independent monitors.
// Bypass expectations follow TLB_KSEG_BYPASS_EN.

module tb_tlb_ctrl;

    localparam int IW = 4;
    localparam int EW = 68;

    typedef struct packed {
        logic [1:0]  code;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [3:0]  waddr;
        logic [67:0] went;
    } op_exp_t;

    logic clk = 1'b0;
    logic resetn;
    logic i_req, d_req, op_valid;
    logic [31:0] i_vaddr, d_vaddr;
    logic [1:0]  op;
    logic [31:0] entryhi, entrylo0, entrylo1;
    logic [IW-1:0] index, wired;
    logic i_ready, i_valid, i_miss, d_ready, d_valid, d_miss, op_ready, op_done;
    logic [31:0] i_paddr, d_paddr, p_index, r_entryhi, r_entrylo0, r_entrylo1;
    logic [31:0] lut_vaddr, lut_paddr;
    logic [7:0]  lut_asid;
    logic        lut_hit;
    logic [IW-1:0] lut_index, tlb_raddr, tlb_waddr;
    logic [EW-1:0] tlb_rentry, tlb_wentry;
    logic          tlb_we;

    logic [EW-1:0] tbl [16];
    logic          load_table;
    int            cyc;
    int            checks = 0;
    int            failures = 0;
    logic [32:0]   iq [$];
    logic [32:0]   dq [$];
    op_exp_t       oq [$];
    logic [32:0]   mon_i, mon_d;
    op_exp_t       mon_op;

    always #5 clk = ~clk;

    tlb_ctrl dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_vaddr(i_vaddr), .i_ready(i_ready),
        .i_valid(i_valid), .i_paddr(i_paddr), .i_miss(i_miss),
        .d_req(d_req), .d_vaddr(d_vaddr), .d_ready(d_ready),
        .d_valid(d_valid), .d_paddr(d_paddr), .d_miss(d_miss),
        .op_valid(op_valid), .op(op), .op_ready(op_ready), .op_done(op_done),
        .entryhi(entryhi), .entrylo0(entrylo0), .entrylo1(entrylo1),
        .index(index), .wired(wired), .p_index(p_index),
        .r_entryhi(r_entryhi), .r_entrylo0(r_entrylo0), .r_entrylo1(r_entrylo1),
        .lut_vaddr(lut_vaddr), .lut_asid(lut_asid),
        .lut_hit(lut_hit), .lut_index(lut_index), .lut_paddr(lut_paddr),
        .tlb_raddr(tlb_raddr), .tlb_rentry(tlb_rentry),
        .tlb_we(tlb_we), .tlb_waddr(tlb_waddr), .tlb_wentry(tlb_wentry)
    );

    // Entry table with distinct out-of-the-way VPN2s so directed addresses miss until written.
    always @(posedge clk) begin
        if (load_table) begin
            for (int k = 0; k < 16; k++)
                tbl[k] <= {19'h7FF00 + 19'(k), 8'hFF, 1'b0, 20'(k), 20'h00100 + 20'(k)};
        end else if (tlb_we) begin
            tbl[tlb_waddr] <= tlb_wentry;
        end
    end

    assign tlb_rentry = tbl[tlb_raddr];

    always_comb begin
        lut_hit   = 1'b0;
        lut_index = '0;
        lut_paddr = '0;
        for (int k = 0; k < 16; k++) begin
            if (!lut_hit && tbl[k][67:49] == lut_vaddr[31:13] &&
                (tbl[k][40] || tbl[k][48:41] == lut_asid)) begin
                lut_hit   = 1'b1;
                lut_index = 4'(k);
                lut_paddr = lut_vaddr[12] ? {tbl[k][19:0], lut_vaddr[11:0]}
                                          : {tbl[k][39:20], lut_vaddr[11:0]};
            end
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Random counts down from 15 through wired, a period of 16-wired, with wired held since reset.
    function automatic logic [3:0] exp_random();
        return 4'(15 - (cyc % (16 - int'(wired))));
    endfunction

    function automatic op_exp_t mk_op(input logic [1:0] code, input logic [31:0] e0,
                                      input logic [31:0] e1, input logic [31:0] e2,
                                      input logic [3:0] waddr, input logic [67:0] went);
        op_exp_t r;
        r.code = code; r.e0 = e0; r.e1 = e1; r.e2 = e2; r.waddr = waddr; r.went = went;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [67:0] actual, input logic [67:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input bit use_d, input logic [31:0] vaddr, input logic [32:0] exp_resp);
        bit accepted = 1'b0;
        if (use_d) begin d_req = 1'b1; d_vaddr = vaddr; end
        else       begin i_req = 1'b1; i_vaddr = vaddr; end
        for (int n = 0; n < 20 && !accepted; n++) begin
            @(negedge clk);
            accepted = use_d ? d_ready : i_ready;
        end
        if (!accepted) begin
            checkOutput("lookup_ready_timeout", 68'd0, 68'd1);
            d_req = 1'b0; i_req = 1'b0;
            return;
        end
        if (use_d) dq.push_back(exp_resp); else iq.push_back(exp_resp);
        @(posedge clk); #1;
        if (use_d) d_req = 1'b0; else i_req = 1'b0;
        @(negedge clk);
        checkOutput(use_d ? "d_valid_latency" : "i_valid_latency", 68'(use_d ? d_valid : i_valid), 68'd1);
        @(posedge clk); #1;
    endtask

    task automatic applyOpStimulus(input logic [1:0] code, input op_exp_t e);
        bit accepted = 1'b0;
        op = code; op_valid = 1'b1;
        for (int n = 0; n < 20 && !accepted; n++) begin
            @(negedge clk);
            accepted = op_ready;
        end
        if (!accepted) begin
            checkOutput("op_ready_timeout", 68'd0, 68'd1);
            op_valid = 1'b0;
            return;
        end
        oq.push_back(e);
        @(posedge clk); #1 op_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (i_valid) begin
                if (iq.size() == 0) checkOutput("i_valid_spurious", 68'd1, 68'd0);
                else begin
                    mon_i = iq.pop_front();
                    checkOutput("i_paddr", 68'(i_paddr), 68'(mon_i[31:0]));
                    checkOutput("i_miss", 68'(i_miss), 68'(mon_i[32]));
                end
            end
            if (d_valid) begin
                if (dq.size() == 0) checkOutput("d_valid_spurious", 68'd1, 68'd0);
                else begin
                    mon_d = dq.pop_front();
                    checkOutput("d_paddr", 68'(d_paddr), 68'(mon_d[31:0]));
                    checkOutput("d_miss", 68'(d_miss), 68'(mon_d[32]));
                end
            end
        end
    end

    // Writes are checked in the done cycle; probe/read registers one cycle later.
    always @(negedge clk) begin
        if (resetn) begin
            if (op_done) begin
                if (oq.size() == 0) checkOutput("op_done_spurious", 68'd1, 68'd0);
                else begin
                    mon_op = oq.pop_front();
                    if (mon_op.code[1]) begin
                        checkOutput("tlb_we", 68'(tlb_we), 68'd1);
                        checkOutput("tlb_waddr", 68'(tlb_waddr),
                                    mon_op.code[0] ? 68'(exp_random()) : 68'(mon_op.waddr));
                        checkOutput("tlb_wentry", 68'(tlb_wentry), mon_op.went);
                    end else begin
                        checkOutput("tlb_we_nonwrite", 68'(tlb_we), 68'd0);
                        @(negedge clk);
                        if (mon_op.code == 2'b00) begin
                            checkOutput("p_index", 68'(p_index), 68'(mon_op.e0));
                        end else begin
                            checkOutput("r_entryhi", 68'(r_entryhi), 68'(mon_op.e0));
                            checkOutput("r_entrylo0", 68'(r_entrylo0), 68'(mon_op.e1));
                            checkOutput("r_entrylo1", 68'(r_entrylo1), 68'(mon_op.e2));
                        end
                    end
                end
            end else if (tlb_we) begin
                checkOutput("tlb_we_spurious", 68'd1, 68'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        resetn = 1'b0; load_table = 1'b1;
        i_req = 1'b0; d_req = 1'b0; op_valid = 1'b0; op = 2'b00;
        i_vaddr = '0; d_vaddr = '0;
        entryhi = 32'h0040_2005; entrylo0 = 32'h0048_D140; entrylo1 = 32'h0150_C840;
        index = 4'd3; wired = 4'd4;
        @(posedge clk); #1 load_table = 1'b0;
        @(negedge clk);
        checkOutput("rst_pulses", 68'({i_valid, d_valid, op_done, tlb_we}), 68'd0);
        checkOutput("rst_p_index", 68'(p_index), 68'd0);
        checkOutput("rst_r_regs", 68'({r_entryhi, r_entrylo0} | 64'(r_entrylo1)), 68'd0);
        checkOutput("rst_op_ready", 68'(op_ready), 68'd1);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkOutput("idle_pulses", 68'({i_valid, d_valid, op_done, tlb_we}), 68'd0);
        end
        @(posedge clk); #1;

        entryhi = 32'h0100_0001; entrylo0 = 32'h0000_0040; entrylo1 = 32'h0000_0080;
        applyOpStimulus(2'b11, mk_op(2'b11, '0, '0, '0, '0,
                        {19'h00800, 8'h01, 1'b0, 20'h00001, 20'h00002}));

        entryhi = 32'h0040_2005; entrylo0 = 32'h0048_D140; entrylo1 = 32'h0150_C840;
        applyOpStimulus(2'b00, mk_op(2'b00, 32'h8000_0000, '0, '0, '0, '0));

        i_req = 1'b1; i_vaddr = 32'h0040_3ABC; d_req = 1'b1; d_vaddr = 32'h0040_2000;
        @(negedge clk);
        checkOutput("both_d_ready", 68'(d_ready), 68'd1);
        checkOutput("both_i_ready", 68'(i_ready), 68'd0);
        dq.push_back({1'b1, 32'h0});
        @(posedge clk); #1 d_req = 1'b0;
        @(negedge clk);
        checkOutput("both_d_valid", 68'(d_valid), 68'd1);
        checkOutput("both_i_ready_next", 68'(i_ready), 68'd1);
        checkOutput("both_i_not_yet", 68'(i_valid), 68'd0);
        iq.push_back({1'b1, 32'h0});
        @(posedge clk); #1 i_req = 1'b0;
        @(negedge clk);
        checkOutput("both_i_valid", 68'(i_valid), 68'd1);
        @(posedge clk); #1;

        index = 4'd3; op = 2'b10; op_valid = 1'b1;
        @(negedge clk);
        checkOutput("wr_op_ready", 68'(op_ready), 68'd1);
        @(posedge clk); #1 op_valid = 1'b0;
        checkOutput("wr_we_before_rst", 68'(tlb_we), 68'd1);
        #1 resetn = 1'b0;
        #1;
        checkOutput("wr_we_in_rst", 68'(tlb_we), 68'd0);
        checkOutput("wr_done_in_rst", 68'(op_done), 68'd0);
        @(negedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_after_rst", 68'(op_ready), 68'd1);
        applyOpStimulus(2'b01, mk_op(2'b01, 32'hFFE0_60FF, 32'h0000_00C0, 32'h0000_40C0, '0, '0));

        applyOpStimulus(2'b10, mk_op(2'b10, '0, '0, '0, 4'd3,
                        {19'h00201, 8'h05, 1'b0, 20'h12345, 20'h54321}));
        applyStimulus(1'b1, 32'h0040_2ABC, {1'b0, 32'h1234_5ABC});
        applyStimulus(1'b0, 32'h0040_3ABC, {1'b0, 32'h5432_1ABC});

        op = 2'b00; op_valid = 1'b1;
        oq.push_back(mk_op(2'b00, 32'h0000_0003, '0, '0, '0, '0));
        oq.push_back(mk_op(2'b00, 32'h0000_0003, '0, '0, '0, '0));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("b2b_op_ready", 68'(op_ready), (c % 2 == 0) ? 68'd1 : 68'd0);
        end
        @(posedge clk); #1 op_valid = 1'b0;
        @(posedge clk); #1;

        op = 2'b01; op_valid = 1'b1; d_req = 1'b1; d_vaddr = 32'h0040_2ABC;
        @(negedge clk);
        checkOutput("prio_d_ready", 68'(d_ready), 68'd0);
        checkOutput("prio_op_ready", 68'(op_ready), 68'd1);
        oq.push_back(mk_op(2'b01, 32'h0040_2005, 32'h0048_D140, 32'h0150_C840, '0, '0));
        @(posedge clk); #1 op_valid = 1'b0;
        @(negedge clk);
        checkOutput("busy_d_ready", 68'(d_ready), 68'd0);
        @(negedge clk);
        checkOutput("after_d_ready", 68'(d_ready), 68'd1);
        dq.push_back({1'b0, 32'h1234_5ABC});
        @(posedge clk); #1 d_req = 1'b0;
        @(posedge clk); #1;

        entryhi = 32'h0040_2006;
        applyStimulus(1'b1, 32'h0040_2ABC, {1'b1, 32'h0});
`ifdef TLB_KSEG_BYPASS_EN
        applyStimulus(1'b0, 32'hBFC0_0000, {1'b0, 32'h1FC0_0000});
`else
        applyStimulus(1'b0, 32'hBFC0_0000, {1'b1, 32'h0});
`endif

        wired = 4'd15;
        entryhi = 32'h0200_0002; entrylo0 = 32'h0000_0041; entrylo1 = 32'h0000_0081;
        repeat (3) @(posedge clk);
        #1;
        applyOpStimulus(2'b11, mk_op(2'b11, '0, '0, '0, '0,
                        {19'h01000, 8'h02, 1'b1, 20'h00001, 20'h00002}));

        repeat (4) @(posedge clk);
        #1;
        checkOutput("p_index_hold", 68'(p_index), 68'd3);
        checkOutput("iq_drained", 68'(iq.size()), 68'd0);
        checkOutput("dq_drained", 68'(dq.size()), 68'd0);
        checkOutput("oq_drained", 68'(oq.size()), 68'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
